bram_access_arbiter: RTL and testbench
======================================

// Module: bram_access_arbiter
// PURPOSE
//  Shares one simple dual-port BRAM between two requesters.
//  - Display scanout: burst reads of a start address plus a length, highest priority.
//  - Host: single-beat read/write with a valid/ready handshake.
//  Sits between the display/host logic and the BRAM instance, and owns both BRAM ports.
//  Also sequences burst addresses, prevents same-address read/write collisions and bounds host-read starvation.
// PARAMETERS
//  WIDTH   8   data width; matches BRAM WIDTH
//  DEPTH   8   address bits; matches BRAM DEPTH; SIZE = 1<<DEPTH words
//  STARVE  16  maximum cycles a pending host read waits during a burst before it steals one slot
// PORTS
//  clk          in   1        single clock; all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  disp_req     in   1        burst request; held until disp_ack
//  disp_addr    in   DEPTH    burst start address
//  disp_len     in   DEPTH+1  burst length in words, 0..SIZE
//  disp_ack     out  1        1-cycle pulse: request accepted, addr/len latched
//  disp_valid   out  1        disp_data valid this cycle
//  disp_data    out  WIDTH    burst read data, in address order
//  disp_last    out  1        with disp_valid: final beat of burst
//  disp_busy    out  1        burst active or display read in flight
//  host_valid   in   1        host transaction request; stable until host_ready
//  host_we      in   1        1 = write, 0 = read
//  host_addr    in   DEPTH    host address
//  host_wdata   in   WIDTH    host write data
//  host_ready   out  1        handshake completes when host_valid & host_ready
//  host_rvalid  out  1        host read data valid (1-cycle pulse)
//  host_rdata   out  WIDTH    host read data
//  bram_re      out  1        to BRAM re
//  bram_addr_rd out  DEPTH    to BRAM addr_rd
//  bram_data_rd in   WIDTH    from BRAM data_rd; registered, valid the cycle after bram_re
//  bram_we      out  1        to BRAM we
//  bram_addr_wr out  DEPTH    to BRAM addr_wr
//  bram_data_wr out  WIDTH    to BRAM data_wr
// BEHAVIOUR
//  Reset:
//  - State = IDLE; burst counters, starvation counter and in-flight tag all cleared.
//  - During reset cycles all outputs are 0, including host_ready and the bram_* strobes.
//  - Reset mid-burst abandons the burst; a read already in flight produces no valid output.
//  FSM:
//  - IDLE -> BURST when disp_req=1 and disp_len!=0. disp_ack pulses and addr/len are latched; the first read issues in the next cycle.
//  - disp_req=1 and disp_len=0: disp_ack pulses, state stays IDLE, no beats.
//  - BURST: one bram_re per cycle at the current address.
//  - Address increments modulo SIZE (0xFF wraps to 0x00). The remaining count decrements.
//  - BURST -> IDLE in the cycle after the last read issues. A new disp_req may be accepted there: one bubble cycle between bursts.
//  Read return (1-cycle latency):
//  - A read issued in cycle t registers a tag (DISP/HOST/none).
//  - In cycle t+1, bram_data_rd is forwarded combinationally to disp_data + disp_valid (+ disp_last) or to host_rdata + host_rvalid.
//  Host reads:
//  - host_ready=1 in IDLE when disp_req=0. Display wins a simultaneous request.
//  - In BURST, a pending host read increments the starvation counter.
//  - When the counter reaches STARVE, that cycle issues the host read (host_ready=1) instead of a burst beat.
//  - On that stolen cycle the burst address/count hold, and disp_valid shows a one-cycle bubble.
//  - The counter clears on every host grant and whenever no host read is pending.
//  Host writes:
//  - Accepted in any state; bram_we asserts in the handshake cycle.
//  - Exception: if host_addr equals the bram_addr_rd issued that cycle, host_ready=0. The write is accepted the next cycle (no same-cycle R/W to one address).
//  - A burst beat therefore returns pre-write data when it collides.
//  Widths and busy:
//  - Length counter is DEPTH+1 bits, so disp_len=SIZE reads every word exactly once.
//  - disp_busy=1 from the cycle after disp_ack through the cycle of disp_last.
// TESTING
//  1. Host write 0x10<=0xA5, then host read 0x10 in IDLE -> host_ready=1 same cycle; next cycle host_rvalid=1, host_rdata=0xA5.
//  2. disp_req addr=0xFE len=4 -> disp_ack 1 cycle; 4 consecutive disp_valid beats with data of 0xFE,0xFF,0x00,0x01; disp_last on beat 4 only.
//  3. Host read pending at start of a 40-beat burst, STARVE=16 -> granted within 17 cycles; exactly one disp_valid bubble; all 40 beats in order.
//  4. Host write to the address read in the same cycle -> host_ready=0 that cycle, 1 the next; that burst beat returns the old value.
//  5. disp_len=0 -> disp_ack only, no disp_valid, stays IDLE. Simultaneous disp_req and host read in IDLE -> display acked, host_ready=0.
//  6. rst asserted at beat 5 of a 20-beat burst -> from the next cycle disp_valid=0, disp_busy=0, no further beats; a new burst then works normally.

Source files
------------

// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter: shares one simple dual-port BRAM between a display burst reader and a host port
module bram_access_arbiter #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int STARVE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             disp_req,
   input  logic [DEPTH-1:0] disp_addr,
   input  logic [DEPTH:0]   disp_len,
   output logic             disp_ack,
   output logic             disp_valid,
   output logic [WIDTH-1:0] disp_data,
   output logic             disp_last,
   output logic             disp_busy,
   input  logic             host_valid,
   input  logic             host_we,
   input  logic [DEPTH-1:0] host_addr,
   input  logic [WIDTH-1:0] host_wdata,
   output logic             host_ready,
   output logic             host_rvalid,
   output logic [WIDTH-1:0] host_rdata,
   output logic             bram_re,
   output logic [DEPTH-1:0] bram_addr_rd,
   input  logic [WIDTH-1:0] bram_data_rd,
   output logic             bram_we,
   output logic [DEPTH-1:0] bram_addr_wr,
   output logic [WIDTH-1:0] bram_data_wr
);
   localparam int SW = $clog2(STARVE + 1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t           state, state_nx;
   logic [DEPTH-1:0] b_addr, b_addr_nx;
   logic [DEPTH:0]   b_cnt, b_cnt_nx;
   logic [SW-1:0]    starve, starve_nx;
   logic             tag_disp, tag_host, tag_last;
   logic             tag_disp_nx, tag_host_nx, tag_last_nx;
   logic             host_rd, steal, wr_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         b_addr   <= '0;
         b_cnt    <= '0;
         starve   <= '0;
         tag_disp <= 1'b0;
         tag_host <= 1'b0;
         tag_last <= 1'b0;
      end else begin
         state    <= state_nx;
         b_addr   <= b_addr_nx;
         b_cnt    <= b_cnt_nx;
         starve   <= starve_nx;
         tag_disp <= tag_disp_nx;
         tag_host <= tag_host_nx;
         tag_last <= tag_last_nx;
      end
   end

   always_comb begin
      host_rd      = host_valid & ~host_we;
      steal        = (state == BURST) & host_rd & (starve == SW'(STARVE));
      state_nx     = state;
      b_addr_nx    = b_addr;
      b_cnt_nx     = b_cnt;
      starve_nx    = '0;
      tag_disp_nx  = 1'b0;
      tag_host_nx  = 1'b0;
      tag_last_nx  = 1'b0;
      disp_ack     = 1'b0;
      host_ready   = 1'b0;
      bram_re      = 1'b0;
      bram_addr_rd = '0;
      if (state == IDLE) begin
         disp_ack = disp_req;
         if (disp_req && disp_len != '0) begin
            state_nx  = BURST;
            b_addr_nx = disp_addr;
            b_cnt_nx  = disp_len;
         end
         if (host_rd && !disp_req) begin
            host_ready   = 1'b1;
            bram_re      = 1'b1;
            bram_addr_rd = host_addr;
            tag_host_nx  = 1'b1;
         end
      end else if (steal) begin
         // starved host read takes this slot; burst position is frozen
         host_ready   = 1'b1;
         bram_re      = 1'b1;
         bram_addr_rd = host_addr;
         tag_host_nx  = 1'b1;
      end else begin
         bram_re      = 1'b1;
         bram_addr_rd = b_addr;
         tag_disp_nx  = 1'b1;
         tag_last_nx  = b_cnt == (DEPTH+1)'(1);
         b_addr_nx    = b_addr + 1'b1;
         b_cnt_nx     = b_cnt - 1'b1;
         state_nx     = tag_last_nx ? IDLE : BURST;
         starve_nx    = host_rd ? starve + 1'b1 : '0;
      end
      // a write to the address being read this cycle waits one cycle
      wr_ok        = host_valid & host_we & ~(bram_re & (bram_addr_rd == host_addr));
      host_ready   = host_ready | wr_ok;
      bram_we      = wr_ok;
      bram_addr_wr = wr_ok ? host_addr : '0;
      bram_data_wr = wr_ok ? host_wdata : '0;
      disp_valid   = tag_disp;
      disp_last    = tag_disp & tag_last;
      disp_data    = tag_disp ? bram_data_rd : '0;
      host_rvalid  = tag_host;
      host_rdata   = tag_host ? bram_data_rd : '0;
      disp_busy    = (state == BURST) | tag_disp;
      if (rst) begin
         disp_ack     = 1'b0;
         host_ready   = 1'b0;
         bram_re      = 1'b0;
         bram_addr_rd = '0;
         bram_we      = 1'b0;
         bram_addr_wr = '0;
         bram_data_wr = '0;
         disp_valid   = 1'b0;
         disp_last    = 1'b0;
         disp_data    = '0;
         host_rvalid  = 1'b0;
         host_rdata   = '0;
         disp_busy    = 1'b0;
      end
   end
endmodule

// File: tb/tb_bram_access_arbiter.sv
// tb_bram_access_arbiter: table vectors, directed corner sequences and random traffic against a memory/queue model
module tb_bram_access_arbiter;
   localparam int STARVE = 16;
   logic       clk = 1'b0;
   logic       rst, mem_init;
   logic       disp_req, disp_ack, disp_valid, disp_last, disp_busy;
   logic [7:0] disp_addr, disp_data;
   logic [8:0] disp_len;
   logic       host_valid, host_we, host_ready, host_rvalid;
   logic [7:0] host_addr, host_wdata, host_rdata;
   logic       bram_re, bram_we;
   logic [7:0] bram_addr_rd, bram_data_rd, bram_addr_wr, bram_data_wr;
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   int         n_cmp = 0, n_err = 0;
   int         q[$];
   bit         hr_pend = 1'b0, idle;
   int         hr_addr = 0, mn;

   bram_access_arbiter #(.WIDTH(8), .DEPTH(8), .STARVE(STARVE)) dut (
      .clk(clk), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len), .disp_ack(disp_ack),
      .disp_valid(disp_valid), .disp_data(disp_data), .disp_last(disp_last), .disp_busy(disp_busy),
      .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .bram_re(bram_re), .bram_addr_rd(bram_addr_rd), .bram_data_rd(bram_data_rd),
      .bram_we(bram_we), .bram_addr_wr(bram_addr_wr), .bram_data_wr(bram_data_wr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int a);
      return 8'((a * 7 + 3) & 255);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // BRAM: registered read, old data on a same-address read/write
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else begin
         if (bram_we) mem[bram_addr_wr] <= bram_data_wr;
         if (bram_re) bram_data_rd <= mem[bram_addr_rd];
      end
   end

   // reference: queue of burst addresses still owed, shadow memory, pending host read
   always @(negedge clk) begin
      if (rst) begin
         if (mem_init) for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
         chk("rst_ctl", {disp_ack, disp_valid, disp_last, disp_busy, host_ready, host_rvalid, bram_re, bram_we}, '0);
         chk("rst_data", {disp_data, host_rdata, bram_addr_rd, bram_addr_wr}, '0);
         chk("rst_wdata", bram_data_wr, '0);
         q.delete();
         hr_pend = 1'b0;
      end else begin
         mn   = q.size();
         idle = mn == 0 || (mn == 1 && disp_valid);
         chk("busy", disp_busy, mn > 0);
         chk("ack", disp_ack, disp_req && idle);
         chk("rvalid", host_rvalid, hr_pend);
         if (hr_pend && host_rvalid) chk("rdata", host_rdata, ref_mem[hr_addr]);
         if (mn == 0) chk("idle_valid", disp_valid, '0);
         else if (disp_valid) begin
            chk("beat_data", disp_data, ref_mem[q[0]]);
            chk("beat_last", disp_last, mn == 1);
            void'(q.pop_front());
         end
         if (!disp_valid) chk("last_alone", disp_last, '0);
         chk("bram_re", bram_re, idle ? (host_valid && !host_we && !disp_req) : 1'b1);
         if (host_valid && host_we) chk("wr_ready", host_ready, !(bram_re && bram_addr_rd == host_addr));
         if (idle && host_valid && !host_we) chk("rd_ready", host_ready, !disp_req);
         chk("bram_we", bram_we, host_valid && host_we && host_ready);
         if (host_valid && host_we && host_ready) chk("wr_port", {bram_addr_wr, bram_data_wr}, {host_addr, host_wdata});
         if (host_valid && !host_we && host_ready) chk("rd_port", {bram_re, bram_addr_rd}, {1'b1, host_addr});
         hr_pend = host_valid && !host_we && host_ready;
         hr_addr = int'(host_addr);
         if (disp_ack && disp_len != 0)
            for (int i = 0; i < int'(disp_len); i++) q.push_back((int'(disp_addr) + i) % 256);
         if (host_valid && host_we && host_ready) ref_mem[host_addr] = host_wdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!disp_busy) break;
         tick();
      end
      chk("drain", disp_busy, '0);
      tick();
   endtask

   task automatic start_burst(input logic [7:0] a, input logic [8:0] l);
      disp_req  = 1'b1;
      disp_addr = a;
      disp_len  = l;
      @(negedge clk);
      chk("start_ack", disp_ack, 1'b1);
      tick();
      disp_req = 1'b0;
   endtask

   task automatic collect(input logic [7:0] a, input int n, input string nm);
      int got = 0;
      for (int k = 0; k < 2 * n + 10 && got < n; k++) begin
         @(negedge clk);
         if (disp_valid) begin
            chk({nm, "_data"}, disp_data, ref_mem[(int'(a) + got) % 256]);
            chk({nm, "_last"}, disp_last, got == n - 1);
            got++;
         end
         tick();
      end
      chk({nm, "_beats"}, got, n);
   endtask

   typedef struct {
      logic       dreq;
      logic       hv, hwe;
      logic [7:0] ha, hd;
      logic       e_ack, e_rdy, e_re, e_we, e_rv;
      logic [7:0] e_rd;
   } vec_t;
   vec_t tbl[7];

   initial begin
      bit d_done, h_done, h_drop;
      int h_wait, beats, grant_k, first_k, last_k, cnt;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h33, 8'h5C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5C};
      rst = 1'b1; mem_init = 1'b1;
      disp_req = 1'b0; disp_addr = '0; disp_len = '0;
      host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      tick(); tick();
      mem_init = 1'b0;
      disp_req = 1'b1; host_valid = 1'b1;
      @(negedge clk);
      chk("rst_held_ack", disp_ack, '0);
      chk("rst_held_ready", host_ready, '0);
      tick();
      rst = 1'b0; disp_req = 1'b0; host_valid = 1'b0;
      // single-cycle IDLE responses, zero-length display requests included
      for (int i = 0; i < 7; i++) begin
         disp_req = tbl[i].dreq; disp_len = '0;
         host_valid = tbl[i].hv; host_we = tbl[i].hwe; host_addr = tbl[i].ha; host_wdata = tbl[i].hd;
         @(negedge clk);
         chk("vec_ack", disp_ack, tbl[i].e_ack);
         chk("vec_ready", host_ready, tbl[i].e_rdy);
         chk("vec_re", bram_re, tbl[i].e_re);
         chk("vec_we", bram_we, tbl[i].e_we);
         chk("vec_busy", disp_busy, '0);
         if (i > 0) chk("vec_rvalid", host_rvalid, tbl[i-1].e_rv);
         if (i > 0 && tbl[i-1].e_rv) chk("vec_rdata", host_rdata, tbl[i-1].e_rd);
         tick();
      end
      disp_req = 1'b0; host_valid = 1'b0;
      @(negedge clk);
      chk("vec_rvalid_end", host_rvalid, tbl[6].e_rv);
      chk("vec_rdata_end", host_rdata, tbl[6].e_rd);
      tick();
      // wrapping burst
      start_burst(8'hFE, 9'd4);
      collect(8'hFE, 4, "wrap");
      drain();
      // host read starved by a long burst
      start_burst(8'h60, 9'd40);
      host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h10;
      grant_k = 0; beats = 0; first_k = 0; last_k = 0;
      for (int k = 1; k <= 80 && last_k == 0; k++) begin
         @(negedge clk);
         if (disp_valid) begin
            beats++;
            if (first_k == 0) first_k = k;
            if (disp_last) last_k = k;
         end
         if (grant_k != 0 && k == grant_k + 1) begin
            chk("steal_rvalid", host_rvalid, 1'b1);
            chk("steal_rdata", host_rdata, 8'hA5);
         end
         if (host_valid && host_ready && grant_k == 0) grant_k = k;
         tick();
         if (grant_k != 0) host_valid = 1'b0;
      end
      chk("steal_granted", grant_k >= 1 && grant_k <= STARVE + 1, 1'b1);
      chk("steal_beats", beats, 40);
      chk("steal_bubbles", last_k - first_k + 1 - beats, 1);
      drain();
      // write colliding with the beat being read
      start_burst(8'h40, 9'd4);
      host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h99;
      @(negedge clk);
      chk("coll_block", host_ready, '0);
      chk("coll_no_we", bram_we, '0);
      tick();
      @(negedge clk);
      chk("coll_accept", host_ready, 1'b1);
      chk("coll_old_valid", disp_valid, 1'b1);
      chk("coll_old_data", disp_data, init_val(8'h40));
      tick();
      host_valid = 1'b0;
      drain();
      host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h40;
      @(negedge clk);
      chk("coll_rd_ready", host_ready, 1'b1);
      tick();
      host_valid = 1'b0;
      @(negedge clk);
      chk("coll_new_data", host_rdata, 8'h99);
      tick();
      // reset in the middle of a burst
      start_burst(8'h80, 9'd20);
      beats = 0;
      for (int k = 0; k < 40 && beats < 5; k++) begin
         @(negedge clk);
         if (disp_valid) beats++;
         if (beats < 5) tick();
      end
      chk("rst_mid_beat5", beats, 5);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", disp_valid, '0);
      chk("rst_mid_busy", disp_busy, '0);
      tick();
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         cnt += int'(disp_valid) + int'(disp_busy);
         tick();
      end
      chk("rst_mid_quiet", cnt, 0);
      start_burst(8'h20, 9'd3);
      collect(8'h20, 3, "after_rst");
      drain();
      // random traffic checked by the reference monitor
      h_wait = 0; h_drop = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         d_done = disp_req && disp_ack;
         h_done = host_valid && host_ready;
         if (host_valid && !h_done) h_wait++;
         if (h_done) h_wait = 0;
         if (h_wait > 200) begin
            chk("host_wait", h_wait, 200);
            h_wait = 0;
            h_drop = 1'b1;
         end
         tick();
         if (d_done) disp_req = 1'b0;
         else if (!disp_req && $urandom_range(0, 7) == 0) begin
            disp_req  = 1'b1;
            disp_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(240, 255));
            disp_len  = ($urandom_range(0, 31) == 0) ? 9'd256 : 9'($urandom_range(0, 40));
         end
         if (h_done || h_drop) host_valid = 1'b0;
         h_drop = 1'b0;
         if (!host_valid && $urandom_range(0, 1) == 1) begin
            host_valid = 1'b1;
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 47));
            host_wdata = 8'($urandom_range(0, 255));
         end
      end
      disp_req = 1'b0; host_valid = 1'b0;
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
